yl3_display_scanner: RTL and testbench

- Upstream feeder for the YL-3 dual-74HC595 serial shifter.
- Holds an 8-digit frame buffer of hex nibbles plus decimal-point and blank masks, decodes each digit to an active-low 7-segment pattern, and time-multiplexes the digits.
- Hands one 16-bit {position, character} word per digit to the shifter over its EN/RDY handshake, then dwells a programmable time before moving to the next digit.

---
 rtl/yl3_pkg.sv | 38 +++
 rtl/yl3_seg_decode.sv | 25 ++
 rtl/yl3_display_scanner.sv | 129 ++++++++++++
 tb/tb_yl3_display_scanner.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yl3_pkg.sv
// ============================================================================
// Module      : yl3_pkg
// Description : Shared constants, segment table and FSM encoding for the
//               YL-3 display scanner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package yl3_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = 3;
  localparam int POS_LSB    = 8;
  localparam int CHAR_LSB   = 0;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {DP,G,F,E,D,C,B,A} for hex 0..F, DP off.
  localparam logic [7:0] SEG_TABLE [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Cycles the scanner waits for the shifter to drop RDY before re-requesting.
  localparam logic [1:0] BUSY_TO_LAST = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    REQ       = 3'd2,
    BUSY      = 3'd3,
    DONE_WAIT = 3'd4,
    DWELL     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/yl3_seg_decode.sv
// ============================================================================
// Module      : yl3_seg_decode
// Description : Hex nibble to active-low 7-segment pattern with DP and blank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yl3_seg_decode
  import yl3_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
    if (dp) seg[7] = 1'b0;
    if (blank) seg = SEG_BLANK;
  end

endmodule

`default_nettype wire

// File: rtl/yl3_display_scanner.sv
// ============================================================================
// Module      : yl3_display_scanner
// Description : 8-digit frame buffer, 7-segment decode and digit multiplexer
//               feeding the YL-3 serial shifter over its EN/RDY handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module yl3_display_scanner
  import yl3_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int CNT_W        = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [31:0] DIGIT_IN,
  input  logic [7:0]  DP_IN,
  input  logic [7:0]  BLANK_IN,
  input  logic        LOAD,
  input  logic        SR_RDY,
  output logic        SR_EN,
  output logic [15:0] SR_DATA,
  output logic [2:0]  DIGIT_IDX,
  output logic        FRAME_DONE
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_sr_en;
  logic [31:0]        r_digits;
  logic [7:0]         r_dp;
  logic [7:0]         r_blank;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_to_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_sr_data;
  logic               r_frame_done;
  logic [7:0]         w_char;
  logic [7:0]         w_pos;

  assign w_pos = 8'b1 << r_idx;

  yl3_seg_decode u_seg_decode (
    .nibble (r_digits[{r_idx, 2'b00} +: 4]),
    .dp     (r_dp[r_idx]),
    .blank  (r_blank[r_idx]),
    .seg    (w_char)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_sr_en      = 1'b0;
    case (r_state)
      IDLE:      if (ENABLE) w_next_state = FETCH;
      FETCH:     w_next_state = REQ;
      REQ: begin
        if (SR_RDY) begin
          w_sr_en      = 1'b1;
          w_next_state = BUSY;
        end
      end
      // A shifter that never dropped RDY missed the request; ask again.
      BUSY: begin
        if (!SR_RDY)                        w_next_state = DONE_WAIT;
        else if (r_to_cnt == BUSY_TO_LAST)  w_next_state = REQ;
      end
      DONE_WAIT: if (SR_RDY) w_next_state = DWELL;
      DWELL:     if (r_cnt == '0) w_next_state = ENABLE ? FETCH : IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_digits <= '0;
      r_dp     <= '0;
      r_blank  <= 8'hFF;
    end else if (LOAD) begin
      r_digits <= DIGIT_IN;
      r_dp     <= DP_IN;
      r_blank  <= BLANK_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sr_data    <= '0;
      r_cnt        <= '0;
      r_to_cnt     <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FETCH: begin
          r_sr_data[POS_LSB  +: 8] <= w_pos;
          r_sr_data[CHAR_LSB +: 8] <= w_char;
        end
        REQ:       r_to_cnt <= '0;
        BUSY:      if (SR_RDY) r_to_cnt <= r_to_cnt + 2'd1;
        DONE_WAIT: if (SR_RDY) r_cnt <= CNT_W'(DWELL_CYCLES - 1);
        DWELL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_idx        <= r_idx + 1'b1;
            r_frame_done <= (r_idx == IDX_W'(NUM_DIGITS - 1));
          end
        end
        default: ;
      endcase
    end
  end

  assign SR_EN      = w_sr_en;
  assign SR_DATA    = r_sr_data;
  assign DIGIT_IDX  = r_idx;
  assign FRAME_DONE = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_yl3_display_scanner.sv
// ============================================================================
// Module      : tb_yl3_display_scanner
// Description : Self-checking bench for yl3_display_scanner with a shifter model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_yl3_display_scanner;

  localparam int DWELL = 10;
  localparam int XFER  = 5;

  logic        CLK      = 1'b0;
  logic        RST_N    = 1'b0;
  logic        ENABLE   = 1'b0;
  logic [31:0] DIGIT_IN = '0;
  logic [7:0]  DP_IN    = '0;
  logic [7:0]  BLANK_IN = '0;
  logic        LOAD     = 1'b0;
  logic        sh_rdy   = 1'b1;
  logic        SR_EN;
  logic [15:0] SR_DATA;
  logic [2:0]  DIGIT_IDX;
  logic        FRAME_DONE;

  yl3_display_scanner #(.DWELL_CYCLES(DWELL), .CNT_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ENABLE     (ENABLE),
    .DIGIT_IN   (DIGIT_IN),
    .DP_IN      (DP_IN),
    .BLANK_IN   (BLANK_IN),
    .LOAD       (LOAD),
    .SR_RDY     (sh_rdy),
    .SR_EN      (SR_EN),
    .SR_DATA    (SR_DATA),
    .DIGIT_IDX  (DIGIT_IDX),
    .FRAME_DONE (FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Shifter model: drops RDY for XFER cycles after an accepted EN.
  int          cyc       = 0;
  int          sh_cnt    = 0;
  int          ign_tok   = 0;
  int          ign_used  = 0;
  int          en_double = 0;
  int          fd_cnt    = 0;
  logic        prev_en   = 1'b0;
  logic [15:0] acc_q [$];
  int          acc_t [$];
  int          en_t  [$];

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    prev_en <= SR_EN;
    if (SR_EN && prev_en) en_double <= en_double + 1;
    if (SR_EN) en_t.push_back(cyc);
    if (sh_cnt > 0) begin
      sh_cnt <= sh_cnt - 1;
      if (sh_cnt == 1) sh_rdy <= 1'b1;
    end else if (SR_EN && sh_rdy) begin
      if (ign_used < ign_tok) begin
        ign_used <= ign_used + 1;
      end else begin
        acc_q.push_back(SR_DATA);
        acc_t.push_back(cyc);
        sh_rdy <= 1'b0;
        sh_cnt <= XFER;
      end
    end
  end

  always @(negedge CLK) if (FRAME_DONE) fd_cnt <= fd_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (acc_q.size() < n && k < 400) begin
      @(negedge CLK);
      k++;
    end
    if (acc_q.size() < n) chk("word_timeout", acc_q.size(), n);
  endtask

  task automatic load(input logic [31:0] dig, input logic [7:0] dp, input logic [7:0] bl);
    DIGIT_IN = dig;
    DP_IN    = dp;
    BLANK_IN = bl;
    LOAD     = 1'b1;
    @(negedge CLK);
    LOAD     = 1'b0;
  endtask

  task automatic wait_frame_done();
    int k    = 0;
    int base = fd_cnt;
    while (!FRAME_DONE && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("frame_done", FRAME_DONE, 1);
    chk("wrap_idx", DIGIT_IDX, 0);
    repeat (3) @(negedge CLK);
    chk("frame_done_pulses", fd_cnt - base, 1);
  endtask

  typedef struct {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [15:0] w [8];
  } vec_t;

  vec_t vt [3];

  initial begin
    int base;
    int nen;
    int k;

    vt[0].dig = 32'h76543210; vt[0].dp = 8'h00; vt[0].blank = 8'h00;
    vt[0].w   = '{16'h01C0, 16'h02F9, 16'h04A4, 16'h08B0,
                  16'h1099, 16'h2092, 16'h4082, 16'h80F8};
    vt[1].dig = 32'h88888888; vt[1].dp = 8'h80; vt[1].blank = 8'h0F;
    vt[1].w   = '{16'h01FF, 16'h02FF, 16'h04FF, 16'h08FF,
                  16'h1080, 16'h2080, 16'h4080, 16'h8000};
    vt[2].dig = 32'hFEDCBA98; vt[2].dp = 8'h55; vt[2].blank = 8'h00;
    vt[2].w   = '{16'h0100, 16'h0290, 16'h0408, 16'h0883,
                  16'h1046, 16'h20A1, 16'h4006, 16'h808E};

    repeat (3) @(negedge CLK);
    chk("rst_sr_en", SR_EN, 0);
    chk("rst_sr_data", SR_DATA, 16'h0000);
    chk("rst_idx", DIGIT_IDX, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Full frames from a stopped scanner at digit 0.
    for (int v = 0; v < 3; v++) begin
      base = acc_q.size();
      load(vt[v].dig, vt[v].dp, vt[v].blank);
      ENABLE = 1'b1;
      k = 0;
      do begin
        @(negedge CLK);
        k++;
      end while (!SR_EN && k < 8);
      chk("en_latency", k, 2);
      wait_words(base + 8);
      ENABLE = 1'b0;
      for (int i = 0; i < 8; i++) chk($sformatf("vec%0d_word%0d", v, i), acc_q[base + i], vt[v].w[i]);
      chk("digit_period", acc_t[base + 1] - acc_t[base], XFER + DWELL + 3);
      wait_frame_done();
      repeat (5) @(negedge CLK);
    end

    // LOAD in digit 1 dwell reaches digit 2; LOAD in digit 2 busy does not.
    base = acc_q.size();
    load(32'h76543210, 8'h00, 8'h00);
    ENABLE = 1'b1;
    wait_words(base + 2);
    repeat (8) @(negedge CLK);
    load(32'h76543E10, 8'h00, 8'h00);
    wait_words(base + 3);
    chk("dwell_load_word", acc_q[base + 2], 16'h0486);
    load(32'h76543510, 8'h00, 8'h00);
    repeat (8) @(negedge CLK);
    chk("busy_load_hold", SR_DATA, 16'h0486);
    wait_words(base + 8);
    ENABLE = 1'b0;
    wait_frame_done();
    base = acc_q.size();
    ENABLE = 1'b1;
    wait_words(base + 3);
    chk("busy_load_next_frame", acc_q[base + 2], 16'h0492);
    wait_words(base + 8);
    ENABLE = 1'b0;
    wait_frame_done();
    repeat (5) @(negedge CLK);

    // ENABLE dropped during digit 3 busy.
    base = acc_q.size();
    ENABLE = 1'b1;
    wait_words(base + 4);
    ENABLE = 1'b0;
    repeat (40) @(negedge CLK);
    chk("stop_idx", DIGIT_IDX, 4);
    chk("stop_no_more_words", acc_q.size(), base + 4);
    ENABLE = 1'b1;
    wait_words(base + 5);
    chk("resume_word", acc_q[base + 4], 16'h1099);
    wait_words(base + 8);
    ENABLE = 1'b0;
    wait_frame_done();
    repeat (5) @(negedge CLK);

    // Shifter ignores one EN, then reset lands mid-busy.
    base = acc_q.size();
    nen  = en_t.size();
    ign_tok = ign_tok + 1;
    ENABLE = 1'b1;
    wait_words(base + 1);
    chk("repulse_count", en_t.size() >= nen + 2, 1);
    chk("repulse_gap", en_t[nen + 1] - en_t[nen], 5);
    chk("repulse_word", acc_q[base], 16'h01C0);
    wait_words(base + 3);
    RST_N = 1'b0;
    #1;
    chk("async_rst_sr_en", SR_EN, 0);
    chk("async_rst_idx", DIGIT_IDX, 0);
    chk("async_rst_sr_data", SR_DATA, 16'h0000);
    chk("async_rst_frame_done", FRAME_DONE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    wait_words(base + 4);
    chk("post_reset_word", acc_q[base + 3], 16'h01FF);
    ENABLE = 1'b0;
    repeat (40) @(negedge CLK);
    chk("no_double_en", en_double, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
